alm_div_pipe: RTL and testbench
===============================

Name: alm_div_pipe

Overview:
- Pipelined approximate logarithmic (Mitchell-style) signed divider, the divide counterpart of the approximate log multipliers in the Logaritmic library.
- Computes a/b by subtracting operand logarithms (leading-one position plus truncated mantissa) and applying a shift-based antilog.
- Three register stages with valid/ready handshakes on both sides and bubble collapsing, for use in streaming datapaths.

Parameters:
- MANT_W, 6: mantissa bits kept after the leading one; legal range 2..14.
- TAG_W, 4: width of the sideband tag carried unchanged with each operation.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- in_valid_i  in  1  operand pair valid.
- in_ready_o  out  1  divider can accept an operand pair this cycle.
- a_i  in  16  dividend, two's complement.
- b_i  in  16  divisor, two's complement.
- tag_i  in  TAG_W  sideband tag.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  downstream accepts the result.
- q_mag_o  out  32  quotient magnitude, unsigned Q16.16.
- q_sign_o  out  1  quotient sign; 1 = negative.
- dz_o  out  1  divide-by-zero flag.
- tag_o  out  TAG_W  tag of the current result.

Behaviour:
- Transfers: an input transfer occurs when in_valid_i & in_ready_o. An output transfer occurs when out_valid_o & out_ready_i.
- Pipeline control: three stages S1, S2, S3, each with a valid bit. A stage loads when its own valid bit is clear or the stage after it advances. in_ready_o = ~S1.v | S1 advances. S3 advances on an output transfer. Result: no bubbles, full throughput of 1/cycle, latency exactly 3 cycles with no stall.
- S1 (log encode):
  - |a|, |b|: exact two's-complement absolute value into 16-bit unsigned; -32768 gives 0x8000.
  - sign = a[15] ^ b[15].
  - k: position of the leading one, 0..15.
  - f: the MANT_W bits just below the leading one, truncated, zero-padded on the right when k < MANT_W.
  - Flags: za = (a==0), zb = (b==0).
- S2 (log subtract):
  - L = {ka,fa} - {kb,fb}, signed, width 4+MANT_W+1.
  - Integer part n = floor(L / 2^MANT_W), range -16..15.
  - Fraction r = L[MANT_W-1:0].
- S3 (antilog): q_mag = ({1,r} << (n+16)) >> MANT_W, truncated toward zero into 32 bits. n+16 lies in 0..31, so no overflow is possible.
- Special cases, applied in S3 in this priority order:
  1. zb: q_mag = 0xFFFFFFFF, q_sign = 0, dz = 1.
  2. za (b nonzero): q_mag = 0, q_sign = 0, dz = 0.
  3. Otherwise dz = 0.
- Output stability: while out_valid_o & ~out_ready_i, q_mag_o, q_sign_o, dz_o and tag_o hold stable. out_valid_o is never deasserted without a transfer.
- Tags: pass through in order, one per operation; no reordering and no drop.
- Reset:
  - All stage valid bits clear, so out_valid_o = 0.
  - q_mag_o = 0, q_sign_o = 0, dz_o = 0, tag_o = 0.
  - in_ready_o = 1 in the first cycle after reset.
  - Reset asserted mid-operation discards all in-flight operations; no result emerges for them.
- Simultaneous load and unload in a full pipe: accepted in the same cycle when out_ready_i = 1, so the pipe stays full.
- in_valid_i with in_ready_o = 0: no transfer. The source holds its data; the block does not latch it.

Test Plan:
- Exact case: a=96, b=3, tag=5, out_ready held high. Required: out_valid_o in cycle 3 with q_mag=0x00200000, q_sign=0, dz=0, tag=5.
- Mantissa borrow: a=100, b=7 → q_mag=0x000E8000 (14.5). Then a=-96, b=3 → q_mag=0x00200000, q_sign=1.
- Range extremes: a=1, b=-32768 → q_mag=0x00000002, q_sign=1. Then a=32767, b=1 → q_mag=0x7F000000, q_sign=0.
- Zero operands: a=5, b=0 → q_mag=0xFFFFFFFF, dz=1, q_sign=0. Then a=0, b=-7 → q_mag=0, dz=0, q_sign=0. Then a=0, b=0 → dz=1.
- Backpressure: stream 8 ops with tags 0..7 while out_ready_i toggles in a pseudo-random pattern. Required:
  - Every result matches a reference model, in tag order.
  - Outputs stay stable during stalls.
  - in_ready_o drops only when all 3 stages are full and out_ready_i=0.
  - Throughput is 1/cycle when out_ready_i=1.
- Reset mid-stream: load 3 ops, assert rst_i for one cycle. Required: out_valid_o=0 and all outputs 0 on the next cycle. A following op (a=96, b=3) emerges 3 cycles after its input transfer, correct and alone.

Source files
------------

// File: rtl/alm_div_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : alm_div_pipe_if
// Description : Handshake and data bundle for the approximate log divider.
//               Operand side: in_valid_i/in_ready_o, a_i, b_i, tag_i.
//               Result side : out_valid_o/out_ready_i, q_mag_o, q_sign_o,
//                             dz_o, tag_o.
//               slave  = divider view, master = producer/consumer view.
// Revision    : 1.0 - initial release
// ============================================================================
interface alm_div_pipe_if #(
    parameter int TAG_W = 4
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [15:0]      a_i;
    logic [15:0]      b_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      q_mag_o;
    logic             q_sign_o;
    logic             dz_o;
    logic [TAG_W-1:0] tag_o;

    modport slave (
        input  in_valid_i, a_i, b_i, tag_i, out_ready_i,
        output in_ready_o, out_valid_o, q_mag_o, q_sign_o, dz_o, tag_o
    );

    modport master (
        output in_valid_i, a_i, b_i, tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, q_mag_o, q_sign_o, dz_o, tag_o
    );
endinterface
`default_nettype wire

// File: rtl/alm_div_pipe.sv
`default_nettype none
// ============================================================================
// Module      : alm_div_pipe
// Description : Three-stage Mitchell-style approximate signed divider.
//               S1 encodes |a|,|b| as leading-one position plus truncated
//               mantissa, S2 subtracts the logarithms, S3 applies the
//               shift-based antilog into an unsigned Q16.16 magnitude.
//               Valid/ready on both sides with bubble collapsing.
// Ports       : clk_i, rst_i (sync, active high)
//               bus (slave) : operand and result handshakes, see interface.
// Revision    : 1.0 - initial release
// ============================================================================
module alm_div_pipe #(
    parameter int MANT_W = 6,
    parameter int TAG_W  = 4
) (
    input  wire logic          clk_i,
    input  wire logic          rst_i,
    alm_div_pipe_if.slave      bus
);
    localparam int c_LW = 4 + MANT_W + 1;

    function automatic logic [3:0] lead_one(input logic [15:0] x);
        lead_one = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (x[i]) lead_one = 4'(i);
        end
    endfunction

    // Shifting the leading one up to bit 15 leaves the mantissa right below
    // it, already zero-padded on the right when k is small.
    function automatic logic [MANT_W-1:0] mant(input logic [15:0] x, input logic [3:0] k);
        logic [15:0] norm;
        norm = x << (4'd15 - k);
        mant = norm[14 -: MANT_W];
    endfunction

    // ---------------- pipeline control ----------------
    logic s1_v_q, s2_v_q, s3_v_q;
    logic w_s1_ld, w_s2_ld, w_s3_ld;

    assign w_s3_ld = ~s3_v_q | bus.out_ready_i;
    assign w_s2_ld = ~s2_v_q | w_s3_ld;
    assign w_s1_ld = ~s1_v_q | w_s2_ld;

    assign bus.in_ready_o = w_s1_ld;

    // ---------------- S1: log encode ----------------
    logic [15:0]       w_abs_a_d, w_abs_b_d;
    logic [3:0]        w_ka_d, w_kb_d;
    logic [MANT_W-1:0] w_fa_d, w_fb_d;

    always_comb begin
        w_abs_a_d = bus.a_i[15] ? (~bus.a_i + 16'd1) : bus.a_i;
        w_abs_b_d = bus.b_i[15] ? (~bus.b_i + 16'd1) : bus.b_i;
        w_ka_d    = lead_one(w_abs_a_d);
        w_kb_d    = lead_one(w_abs_b_d);
        w_fa_d    = mant(w_abs_a_d, w_ka_d);
        w_fb_d    = mant(w_abs_b_d, w_kb_d);
    end

    logic              s1_sign_q, s1_za_q, s1_zb_q;
    logic [3:0]        s1_ka_q, s1_kb_q;
    logic [MANT_W-1:0] s1_fa_q, s1_fb_q;
    logic [TAG_W-1:0]  s1_tag_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_v_q    <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_za_q   <= 1'b0;
            s1_zb_q   <= 1'b0;
            s1_ka_q   <= '0;
            s1_kb_q   <= '0;
            s1_fa_q   <= '0;
            s1_fb_q   <= '0;
            s1_tag_q  <= '0;
        end else if (w_s1_ld) begin
            s1_v_q <= bus.in_valid_i;
            if (bus.in_valid_i) begin
                s1_sign_q <= bus.a_i[15] ^ bus.b_i[15];
                s1_za_q   <= (bus.a_i == 16'd0);
                s1_zb_q   <= (bus.b_i == 16'd0);
                s1_ka_q   <= w_ka_d;
                s1_kb_q   <= w_kb_d;
                s1_fa_q   <= w_fa_d;
                s1_fb_q   <= w_fb_d;
                s1_tag_q  <= bus.tag_i;
            end
        end
    end

    // ---------------- S2: log subtract ----------------
    // Two's-complement difference; its top bits are floor(L / 2^MANT_W).
    logic [c_LW-1:0] w_l_d;
    assign w_l_d = {1'b0, s1_ka_q, s1_fa_q} - {1'b0, s1_kb_q, s1_fb_q};

    logic              s2_sign_q, s2_za_q, s2_zb_q;
    logic [4:0]        s2_n_q;
    logic [MANT_W-1:0] s2_r_q;
    logic [TAG_W-1:0]  s2_tag_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s2_v_q    <= 1'b0;
            s2_sign_q <= 1'b0;
            s2_za_q   <= 1'b0;
            s2_zb_q   <= 1'b0;
            s2_n_q    <= '0;
            s2_r_q    <= '0;
            s2_tag_q  <= '0;
        end else if (w_s2_ld) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_sign_q <= s1_sign_q;
                s2_za_q   <= s1_za_q;
                s2_zb_q   <= s1_zb_q;
                s2_n_q    <= w_l_d[c_LW-1:MANT_W];
                s2_r_q    <= w_l_d[MANT_W-1:0];
                s2_tag_q  <= s1_tag_q;
            end
        end
    end

    // ---------------- S3: antilog ----------------
    // n+16 for a 5-bit signed n in -16..15 is just n with its MSB flipped.
    logic [4:0]         w_sh_d;
    logic [MANT_W+31:0] w_wide_d;
    logic [31:0]        w_mag_d;
    logic               w_sign_d, w_dz_d;

    always_comb begin
        w_sh_d   = {~s2_n_q[4], s2_n_q[3:0]};
        w_wide_d = {31'd0, 1'b1, s2_r_q} << w_sh_d;
        w_mag_d  = w_wide_d[MANT_W+31:MANT_W];
        w_sign_d = s2_sign_q;
        w_dz_d   = 1'b0;
        if (s2_zb_q) begin
            w_mag_d  = 32'hFFFF_FFFF;
            w_sign_d = 1'b0;
            w_dz_d   = 1'b1;
        end else if (s2_za_q) begin
            w_mag_d  = 32'd0;
            w_sign_d = 1'b0;
        end
    end

    logic [31:0]      s3_mag_q;
    logic             s3_sign_q, s3_dz_q;
    logic [TAG_W-1:0] s3_tag_q;

    // Result fields only change when a new operation lands, so they hold
    // steady through any stall.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s3_v_q    <= 1'b0;
            s3_mag_q  <= '0;
            s3_sign_q <= 1'b0;
            s3_dz_q   <= 1'b0;
            s3_tag_q  <= '0;
        end else if (w_s3_ld) begin
            s3_v_q <= s2_v_q;
            if (s2_v_q) begin
                s3_mag_q  <= w_mag_d;
                s3_sign_q <= w_sign_d;
                s3_dz_q   <= w_dz_d;
                s3_tag_q  <= s2_tag_q;
            end
        end
    end

    assign bus.out_valid_o = s3_v_q;
    assign bus.q_mag_o     = s3_mag_q;
    assign bus.q_sign_o    = s3_sign_q;
    assign bus.dz_o        = s3_dz_q;
    assign bus.tag_o       = s3_tag_q;
endmodule
`default_nettype wire

// File: tb/tb_alm_div_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_alm_div_pipe
// Description : Self-checking bench for alm_div_pipe: directed cases with
//               latency checks, randomized backpressure streams against an
//               arithmetic reference model, and mid-stream reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alm_div_pipe;
    localparam int M  = 6;
    localparam int TW = 4;

    typedef struct {
        logic [31:0]   mag;
        logic          sign;
        logic          dz;
        logic [TW-1:0] tag;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alm_div_pipe_if #(.TAG_W(TW)) bus ();
    alm_div_pipe #(.MANT_W(M), .TAG_W(TW)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int   tests = 0;
    int   fails = 0;
    res_t sb[$];
    logic ps = 1'b0;
    res_t held;

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", nm, obs, exp);
        end
    endtask

    // log2 approximation: integer part k, fraction = next M bits truncated.
    function automatic longint logv(input longint m);
        longint k = 0;
        longint f;
        while ((m >> (k + 1)) != 0) k++;
        f = ((m << M) >> k) - (longint'(1) << M);
        return k * (longint'(1) << M) + f;
    endfunction

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b, input logic [TW-1:0] tg);
        res_t   o;
        longint ma, mb, l, r, n, q;
        ma = a[15] ? (65536 - longint'(a)) : longint'(a);
        mb = b[15] ? (65536 - longint'(b)) : longint'(b);
        o.tag = tg;
        if (b == 16'd0) begin
            o.mag = 32'hFFFF_FFFF; o.sign = 1'b0; o.dz = 1'b1;
        end else if (a == 16'd0) begin
            o.mag = 32'd0; o.sign = 1'b0; o.dz = 1'b0;
        end else begin
            l = logv(ma) - logv(mb);
            r = l & ((longint'(1) << M) - 1);
            n = (l - r) / (longint'(1) << M);
            q = (((longint'(1) << M) + r) << (n + 16)) >> M;
            o.mag = q[31:0]; o.sign = a[15] ^ b[15]; o.dz = 1'b0;
        end
        return o;
    endfunction

    // One negedge-aligned cycle with scoreboard and handshake checks.
    task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b,
                        input logic [TW-1:0] tg, input logic ordy, output logic acc);
        res_t e;
        @(negedge clk);
        bus.in_valid_i = iv; bus.a_i = a; bus.b_i = b; bus.tag_i = tg;
        bus.out_ready_i = ordy;
        #1;
        chk("in_ready", bus.in_ready_o, !(sb.size() == 3 && !ordy));
        if (ps) begin
            chk("stall_valid", bus.out_valid_o, 1'b1);
            chk("stall_mag", bus.q_mag_o, held.mag);
            chk("stall_sign", bus.q_sign_o, held.sign);
            chk("stall_dz", bus.dz_o, held.dz);
            chk("stall_tag", bus.tag_o, held.tag);
        end
        if (bus.out_valid_o && ordy) begin
            chk("sb_nonempty", sb.size() != 0, 1'b1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_mag", bus.q_mag_o, e.mag);
                chk("out_sign", bus.q_sign_o, e.sign);
                chk("out_dz", bus.dz_o, e.dz);
                chk("out_tag", bus.tag_o, e.tag);
            end
        end
        ps = bus.out_valid_o && !ordy;
        held.mag = bus.q_mag_o; held.sign = bus.q_sign_o;
        held.dz = bus.dz_o; held.tag = bus.tag_o;
        acc = iv && bus.in_ready_o;
        if (acc) sb.push_back(model(a, b, tg));
    endtask

    // Lone operation into an empty pipe: checks latency and the exact result.
    task automatic run_single(input string nm, input logic [15:0] a, input logic [15:0] b,
                              input logic [TW-1:0] tg, input logic [31:0] emag,
                              input logic esign, input logic edz);
        int lat;
        @(negedge clk);
        bus.in_valid_i = 1'b1; bus.a_i = a; bus.b_i = b; bus.tag_i = tg;
        bus.out_ready_i = 1'b1;
        #1;
        chk({nm, "_rdy"}, bus.in_ready_o, 1'b1);
        @(posedge clk); #1;
        bus.in_valid_i = 1'b0;
        lat = 1;
        while (!bus.out_valid_o && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({nm, "_lat"}, lat, 3);
        chk({nm, "_mag"}, bus.q_mag_o, emag);
        chk({nm, "_sign"}, bus.q_sign_o, esign);
        chk({nm, "_dz"}, bus.dz_o, edz);
        chk({nm, "_tag"}, bus.tag_o, tg);
        @(posedge clk); #1;
        chk({nm, "_alone"}, bus.out_valid_o, 1'b0);
    endtask

    function automatic logic [15:0] rand_op();
        case ($urandom_range(0, 9))
            0:       return 16'd0;
            1:       return 16'h8000;
            2:       return 16'(1);
            3:       return 16'h7FFF;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        logic acc;
        int   sent;
        bus.in_valid_i = 1'b0; bus.a_i = '0; bus.b_i = '0; bus.tag_i = '0;
        bus.out_ready_i = 1'b1;

        // Reset state
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_valid", bus.out_valid_o, 1'b0);
        chk("rst_mag", bus.q_mag_o, 32'd0);
        chk("rst_sign", bus.q_sign_o, 1'b0);
        chk("rst_dz", bus.dz_o, 1'b0);
        chk("rst_tag", bus.tag_o, 4'd0);
        chk("rst_rdy", bus.in_ready_o, 1'b1);

        // Directed cases
        run_single("exact",    16'd96,    16'd3,     4'd5, 32'h0020_0000, 1'b0, 1'b0);
        run_single("borrow",   16'd100,   16'd7,     4'd1, 32'h000E_8000, 1'b0, 1'b0);
        run_single("neg",      -16'sd96,  16'd3,     4'd2, 32'h0020_0000, 1'b1, 1'b0);
        run_single("tiny",     16'd1,     16'h8000,  4'd3, 32'h0000_0002, 1'b1, 1'b0);
        run_single("huge",     16'd32767, 16'd1,     4'd4, 32'h7F00_0000, 1'b0, 1'b0);
        run_single("divzero",  16'd5,     16'd0,     4'd6, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run_single("zero_a",   16'd0,     -16'sd7,   4'd7, 32'h0000_0000, 1'b0, 1'b0);
        run_single("zero_ab",  16'd0,     16'd0,     4'd8, 32'hFFFF_FFFF, 1'b0, 1'b1);

        // Backpressure: 8 ops, tags 0..7, random out_ready
        ps = 1'b0;
        sent = 0;
        for (int c = 0; c < 200 && sent < 8; c++) begin
            step(1'b1, rand_op(), rand_op(), 4'(sent), 1'($urandom), acc);
            if (acc) sent++;
        end
        chk("bp_sent", sent, 8);
        for (int c = 0; c < 30 && sb.size() != 0; c++) step(1'b0, 16'd0, 16'd0, 4'd0, 1'b1, acc);
        chk("bp_drain", sb.size(), 0);

        // Longer random stream with random valid and ready
        sent = 0;
        for (int c = 0; c < 1500 && sent < 300; c++) begin
            step(1'($urandom_range(0, 3) != 0), rand_op(), rand_op(), 4'($urandom),
                 1'($urandom_range(0, 2) != 0), acc);
            if (acc) sent++;
        end
        chk("rnd_sent", sent, 300);
        for (int c = 0; c < 30 && sb.size() != 0; c++) step(1'b0, 16'd0, 16'd0, 4'd0, 1'b1, acc);
        chk("rnd_drain", sb.size(), 0);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) step(1'b1, 16'd1000, 16'd3, 4'(i + 9), 1'b0, acc);
        @(negedge clk);
        bus.in_valid_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_valid", bus.out_valid_o, 1'b0);
        chk("mrst_mag", bus.q_mag_o, 32'd0);
        chk("mrst_sign", bus.q_sign_o, 1'b0);
        chk("mrst_dz", bus.dz_o, 1'b0);
        chk("mrst_tag", bus.tag_o, 4'd0);
        chk("mrst_rdy", bus.in_ready_o, 1'b1);
        sb.delete();
        ps = 1'b0;
        run_single("after_rst", 16'd96, 16'd3, 4'd5, 32'h0020_0000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
`default_nettype wire
